// File: rtl/ofs_plat_prim_fifo_ram_prefetch_pkg.sv
// Helpers shared by the RAM-backed prefetch FIFO.
// Block-local types and sizes live in the modules that use them.
package ofs_plat_prim_fifo_ram_prefetch_pkg;

  function automatic logic almost_full_f(int n_entries, int occupancy, int threshold);
    return (n_entries - occupancy) <= threshold;
  endfunction

endpackage

// File: rtl/ofs_plat_prim_fifo_ram_prefetch_if.sv
// Enqueue/dequeue handshake bundle for the RAM-backed prefetch FIFO.
interface ofs_plat_prim_fifo_ram_prefetch_if #(
  parameter int N_DATA_BITS = 64
);
  import ofs_plat_prim_fifo_ram_prefetch_pkg::*;

  logic                   enq_en;
  logic [N_DATA_BITS-1:0] enq_data;
  logic                   notFull;
  logic                   almostFull;
  logic                   deq_en;
  logic [N_DATA_BITS-1:0] first;
  logic                   notEmpty;

  modport master (
    output enq_en, enq_data, deq_en,
    input  notFull, almostFull, first, notEmpty
  );

  modport slave (
    input  enq_en, enq_data, deq_en,
    output notFull, almostFull, first, notEmpty
  );

endinterface

// File: rtl/ofs_plat_prim_fifo_ram_prefetch_buf.sv
// Small register FIFO that holds RAM responses; entry 0 is always the head,
// so the head output comes straight from a flop.
module ofs_plat_prim_fifo_ram_prefetch_buf
  import ofs_plat_prim_fifo_ram_prefetch_pkg::*;
#(
  parameter  int DEPTH       = 4,
  parameter  int N_DATA_BITS = 64,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [N_DATA_BITS-1:0] push_data,
  input  logic                   pop,
  output logic [N_DATA_BITS-1:0] head,
  output logic [CW-1:0]          count
);

  logic [N_DATA_BITS-1:0] data_p0 [DEPTH];
  logic [CW-1:0]          cnt;
  int                     wr_idx;

  // A push lands just behind the last valid entry after this cycle's shift
  always_comb begin
    wr_idx = int'(cnt) - (pop ? 1 : 0);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (i == wr_idx)) data_p0[i] <= push_data;
      else if (pop)              data_p0[i] <= data_p0[(i < DEPTH-1) ? i+1 : i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt <= '0;
    else          cnt <= cnt + CW'(push) - CW'(pop);
  end

  assign head  = data_p0[0];
  assign count = cnt;

endmodule

// File: rtl/ofs_plat_prim_ram_simple.sv
// Simple dual-port RAM: one write port, one read port with 1 + N_OUTPUT_REG_STAGES
// cycles of read latency. Contents are never reset.
module ofs_plat_prim_ram_simple #(
  parameter int N_ENTRIES            = 32,
  parameter int N_DATA_BITS          = 64,
  parameter int N_OUTPUT_REG_STAGES  = 0,
  parameter int REGISTER_WRITES      = 0,
  parameter int BYPASS_FULL_PIPELINE = 0
) (
  input  logic                         clk,
  input  logic [$clog2(N_ENTRIES)-1:0] waddr,
  input  logic                         wen,
  input  logic [N_DATA_BITS-1:0]       wdata,
  input  logic [$clog2(N_ENTRIES)-1:0] raddr,
  output logic [N_DATA_BITS-1:0]       rdata
);

  logic [N_DATA_BITS-1:0]       mem [N_ENTRIES];
  logic [$clog2(N_ENTRIES)-1:0] waddr_w;
  logic                         wen_w;
  logic [N_DATA_BITS-1:0]       wdata_w;

  generate
    if (REGISTER_WRITES != 0) begin : g_wr_reg
      always_ff @(posedge clk) begin
        waddr_w <= waddr;
        wen_w   <= wen;
        wdata_w <= wdata;
      end
    end else begin : g_wr_comb
      assign waddr_w = waddr;
      assign wen_w   = wen;
      assign wdata_w = wdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (wen_w) mem[waddr_w] <= wdata_w;
  end

  // Stage p0 is the array read; p1.. are the optional output registers
  logic [N_DATA_BITS-1:0] rd_p [N_OUTPUT_REG_STAGES+1];

  always_ff @(posedge clk) begin
    rd_p[0] <= mem[raddr];
    for (int i = 1; i <= N_OUTPUT_REG_STAGES; i++) rd_p[i] <= rd_p[i-1];
  end

  assign rdata = (BYPASS_FULL_PIPELINE != 0) ? rd_p[0] : rd_p[N_OUTPUT_REG_STAGES];

endmodule

// File: rtl/ofs_plat_prim_fifo_ram_prefetch.sv
// Deep FIFO in block RAM with a prefetch buffer that hides the RAM read
// latency, giving a registered show-ahead head and one dequeue per cycle.
module ofs_plat_prim_fifo_ram_prefetch
  import ofs_plat_prim_fifo_ram_prefetch_pkg::*;
#(
  parameter int N_ENTRIES           = 32,
  parameter int N_DATA_BITS         = 64,
  parameter int N_OUTPUT_REG_STAGES = 1,
  parameter int THRESHOLD           = 2
) (
  input  logic clk,
  input  logic reset_n,
  ofs_plat_prim_fifo_ram_prefetch_if.slave fifo
);

  localparam int L         = 1 + N_OUTPUT_REG_STAGES;
  localparam int BUF_DEPTH = L + 2;
  localparam int AW        = $clog2(N_ENTRIES);
  localparam int BCW       = $clog2(BUF_DEPTH + 1);

  typedef logic [AW-1:0] t_addr;
  typedef logic [AW:0]   t_count;

  t_addr                  wr_ptr;
  t_addr                  rd_ptr;
  t_count                 occ;
  t_count                 occ_next;
  logic                   not_full;
  logic                   almost_full;
  logic [L-1:0]           rd_vld_p;
  logic [BCW-1:0]         buf_cnt;
  logic [N_DATA_BITS-1:0] ram_rdata;
  logic [N_DATA_BITS-1:0] buf_head;
  logic                   deq_ok;
  logic                   enq_ok;
  logic                   rd_issue;
  logic                   rd_done;
  int                     pending;

  // A full FIFO still accepts an enq paired with a deq: the dequeued entry is
  // already out of RAM, so the slot at wr_ptr is free.
  always_comb begin
    deq_ok   = fifo.deq_en && (buf_cnt != '0);
    enq_ok   = fifo.enq_en && (not_full || deq_ok);
    pending  = int'(buf_cnt) + $countones(rd_vld_p);
    rd_issue = (rd_ptr != wr_ptr) && (pending < BUF_DEPTH);
    rd_done  = rd_vld_p[L-1];
    occ_next = occ + t_count'(enq_ok) - t_count'(deq_ok);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occ         <= '0;
      rd_vld_p    <= '0;
      not_full    <= 1'b1;
      almost_full <= almost_full_f(N_ENTRIES, 0, THRESHOLD);
    end else begin
      if (enq_ok)   wr_ptr <= wr_ptr + t_addr'(1);
      if (rd_issue) rd_ptr <= rd_ptr + t_addr'(1);
      rd_vld_p    <= (rd_vld_p << 1) | L'(rd_issue);
      occ         <= occ_next;
      not_full    <= occ_next < t_count'(N_ENTRIES);
      almost_full <= almost_full_f(N_ENTRIES, int'(occ_next), THRESHOLD);
    end
  end

  ofs_plat_prim_ram_simple #(
    .N_ENTRIES            (N_ENTRIES),
    .N_DATA_BITS          (N_DATA_BITS),
    .N_OUTPUT_REG_STAGES  (N_OUTPUT_REG_STAGES),
    .REGISTER_WRITES      (0),
    .BYPASS_FULL_PIPELINE (0)
  ) ram (
    .clk   (clk),
    .waddr (wr_ptr),
    .wen   (enq_ok),
    .wdata (fifo.enq_data),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // RAM responses leave the valid pipe and enter the prefetch buffer
  ofs_plat_prim_fifo_ram_prefetch_buf #(
    .DEPTH       (BUF_DEPTH),
    .N_DATA_BITS (N_DATA_BITS)
  ) pf_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (rd_done),
    .push_data (ram_rdata),
    .pop       (deq_ok),
    .head      (buf_head),
    .count     (buf_cnt)
  );

  assign fifo.notFull    = not_full;
  assign fifo.almostFull = almost_full;
  assign fifo.first      = buf_head;
  assign fifo.notEmpty   = (buf_cnt != '0);

  enq_when_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo.enq_en && !enq_ok));
  deq_when_empty: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo.deq_en && (buf_cnt == '0)));

endmodule

// File: tb/tb_ofs_plat_prim_fifo_ram_prefetch.sv
// Bench for the RAM prefetch FIFO: three instances (output stages 1, 0, 3)
// checked every cycle against a queue model in which an entry becomes visible
// L+1 edges after its enqueue.
module tb_ofs_plat_prim_fifo_ram_prefetch;

  localparam int N   = 32;
  localparam int DW  = 64;
  localparam int THR = 2;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          enq_en   [3];
  logic [DW-1:0] enq_data [3];
  logic          deq_en   [3];
  logic          nf  [3];
  logic          af  [3];
  logic          ne  [3];
  logic [DW-1:0] fst [3];

  ofs_plat_prim_fifo_ram_prefetch_if #(.N_DATA_BITS(DW)) if0 ();
  ofs_plat_prim_fifo_ram_prefetch_if #(.N_DATA_BITS(DW)) if1 ();
  ofs_plat_prim_fifo_ram_prefetch_if #(.N_DATA_BITS(DW)) if2 ();

  assign if0.enq_en = enq_en[0]; assign if0.enq_data = enq_data[0]; assign if0.deq_en = deq_en[0];
  assign if1.enq_en = enq_en[1]; assign if1.enq_data = enq_data[1]; assign if1.deq_en = deq_en[1];
  assign if2.enq_en = enq_en[2]; assign if2.enq_data = enq_data[2]; assign if2.deq_en = deq_en[2];
  assign nf[0] = if0.notFull; assign af[0] = if0.almostFull; assign ne[0] = if0.notEmpty; assign fst[0] = if0.first;
  assign nf[1] = if1.notFull; assign af[1] = if1.almostFull; assign ne[1] = if1.notEmpty; assign fst[1] = if1.first;
  assign nf[2] = if2.notFull; assign af[2] = if2.almostFull; assign ne[2] = if2.notEmpty; assign fst[2] = if2.first;

  ofs_plat_prim_fifo_ram_prefetch #(.N_ENTRIES(N), .N_DATA_BITS(DW), .N_OUTPUT_REG_STAGES(1), .THRESHOLD(THR))
    u0 (.clk(clk), .reset_n(reset_n), .fifo(if0));
  ofs_plat_prim_fifo_ram_prefetch #(.N_ENTRIES(N), .N_DATA_BITS(DW), .N_OUTPUT_REG_STAGES(0), .THRESHOLD(THR))
    u1 (.clk(clk), .reset_n(reset_n), .fifo(if1));
  ofs_plat_prim_fifo_ram_prefetch #(.N_ENTRIES(N), .N_DATA_BITS(DW), .N_OUTPUT_REG_STAGES(3), .THRESHOLD(THR))
    u2 (.clk(clk), .reset_n(reset_n), .fifo(if2));

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  function automatic void chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst=%0d got=%h want=%h t=%0t", nm, k, act, exp, $time);
    end
  endfunction

  // Reference model: per-instance circular queue of (data, enqueue cycle)
  int            cyc = 0;
  logic [DW-1:0] md [3][64];
  int            mt [3][64];
  int            mh [3] = '{0, 0, 0};
  int            mn [3] = '{0, 0, 0};

  function automatic int lat(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 4;
  endfunction

  function automatic logic m_ne(input int k);
    return (mn[k] > 0) && ((cyc - mt[k][mh[k]]) >= lat(k) + 1);
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic da, ea;
      if (!reset_n) begin
        mh[k] = 0;
        mn[k] = 0;
      end else begin
        da = deq_en[k] && m_ne(k);
        ea = enq_en[k] && ((mn[k] < N) || da);
        if (da) begin
          mh[k] = (mh[k] + 1) % 64;
          mn[k]--;
        end
        if (ea) begin
          md[k][(mh[k] + mn[k]) % 64] = enq_data[k];
          mt[k][(mh[k] + mn[k]) % 64] = cyc + 1;
          mn[k]++;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk("notFull", k, 64'(nf[k]), 64'(mn[k] < N));
        chk("almostFull", k, 64'(af[k]), 64'((N - mn[k]) <= THR));
        chk("notEmpty", k, 64'(ne[k]), 64'(m_ne(k)));
        if (m_ne(k)) chk("first", k, fst[k], md[k][mh[k]]);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int got, bubbles;
    logic [63:0] exp;
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      enq_en[k] = 1'b0; deq_en[k] = 1'b0; enq_data[k] = '0;
    end
    step();
    chk_en = 1'b1;
    step();
    reset_n = 1'b1;
    chk("rst_notEmpty", 0, 64'(ne[0]), 64'd0);
    chk("rst_notFull", 0, 64'(nf[0]), 64'd1);
    chk("rst_almostFull", 0, 64'(af[0]), 64'd0);

    // Single entry latency: visible after the third edge
    enq_en[0] = 1'b1; enq_data[0] = 64'hA5;
    step();
    enq_en[0] = 1'b0;
    chk("lat_e0", 0, 64'(ne[0]), 64'd0);
    step(); chk("lat_e1", 0, 64'(ne[0]), 64'd0);
    step(); chk("lat_e2", 0, 64'(ne[0]), 64'd0);
    step(); chk("lat_e3", 0, 64'(ne[0]), 64'd1);
    chk("lat_first", 0, fst[0], 64'hA5);
    deq_en[0] = 1'b1;
    step();
    deq_en[0] = 1'b0;
    chk("lat_deq_empty", 0, 64'(ne[0]), 64'd0);

    // Fill to capacity
    for (int i = 0; i < N; i++) begin
      enq_en[0] = 1'b1; enq_data[0] = 64'(i);
      step();
      if (i == 28) chk("fill_af29", 0, 64'(af[0]), 64'd0);
      if (i == 29) chk("fill_af30", 0, 64'(af[0]), 64'd1);
      if (i == 30) chk("fill_nf31", 0, 64'(nf[0]), 64'd1);
      if (i == 31) chk("fill_nf32", 0, 64'(nf[0]), 64'd0);
    end
    enq_en[0] = 1'b0;
    step();
    chk("full_first", 0, fst[0], 64'd0);

    // Full boundary: paired enq+deq keeps it full
    for (int j = 0; j < 4; j++) begin
      enq_en[0] = 1'b1; enq_data[0] = 64'(100 + j); deq_en[0] = 1'b1;
      step();
      chk("full_pair_nf", 0, 64'(nf[0]), 64'd0);
      chk("full_pair_first", 0, fst[0], 64'(j + 1));
    end
    enq_en[0] = 1'b0; deq_en[0] = 1'b0;

    got = 0;
    for (int c = 0; c < 300 && got < N; c++) begin
      deq_en[0] = ne[0];
      if (ne[0]) begin
        exp = (got < 28) ? 64'(got + 4) : 64'(100 + got - 28);
        chk("drain_order", 0, fst[0], exp);
        got++;
      end
      step();
    end
    deq_en[0] = 1'b0;
    chk("drain_cnt", 0, 64'(got), 64'(N));
    chk("drain_empty", 0, 64'(ne[0]), 64'd0);
    chk("drain_nf", 0, 64'(nf[0]), 64'd1);

    // Streaming: continuous enq, deq whenever the head is valid
    bubbles = 0;
    for (int i = 0; i < 1000; i++) begin
      enq_en[0] = 1'b1; enq_data[0] = 64'(1000 + i);
      deq_en[0] = ne[0];
      if (i >= 4 && !ne[0]) bubbles++;
      step();
    end
    enq_en[0] = 1'b0;
    chk("stream_bubbles", 0, 64'(bubbles), 64'd0);
    for (int c = 0; c < 100 && (ne[0] || mn[0] > 0); c++) begin
      deq_en[0] = ne[0];
      step();
    end
    deq_en[0] = 1'b0;
    chk("stream_drained", 0, 64'(ne[0]), 64'd0);

    // Reset with entries buffered and reads in flight
    for (int i = 0; i < 10; i++) begin
      enq_en[0] = 1'b1; enq_data[0] = 64'h200 + 64'(i);
      step();
    end
    enq_en[0] = 1'b0;
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("mrst_notEmpty", 0, 64'(ne[0]), 64'd0);
    chk("mrst_notFull", 0, 64'(nf[0]), 64'd1);
    enq_en[0] = 1'b1; enq_data[0] = 64'h77;
    step();
    enq_en[0] = 1'b0;
    step(); step(); step();
    chk("mrst_ne", 0, 64'(ne[0]), 64'd1);
    chk("mrst_first", 0, fst[0], 64'h77);
    deq_en[0] = 1'b1;
    step();
    deq_en[0] = 1'b0;

    // Random traffic on all three latency configurations
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        logic wd, we;
        wd = ($urandom % 100 < 70) && m_ne(k);
        we = ($urandom % 100 < 50) && ((mn[k] < N) || wd);
        deq_en[k]   = wd;
        enq_en[k]   = we;
        enq_data[k] = {$urandom, $urandom};
      end
      step();
    end
    for (int k = 0; k < 3; k++) enq_en[k] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      for (int k = 0; k < 3; k++) deq_en[k] = m_ne(k);
      step();
    end
    for (int k = 0; k < 3; k++) begin
      deq_en[k] = 1'b0;
      chk("rand_drained", k, 64'(ne[k]), 64'd0);
    end
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
